// File: rtl/mem_lsu_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_pkg
// Brief    : Op encodings, bus size codes and queue entry type for the LSU queue.
// Revision : 1.0  initial release
// ============================================================================
package mem_lsu_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef struct packed {
        logic        is_store;
        logic [2:0]  op;
        logic [1:0]  off;
        logic        done;
        logic        cancel;
        logic [31:0] data;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/mem_lsu_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_queue_if
// Brief    : sram-like bus between the LSU queue (master) and memory (slave).
// Revision : 1.0  initial release
// ============================================================================
interface mem_lsu_queue_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_lsu_queue_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_ext
// Brief    : Selects the addressed byte/half of read data and sign/zero-extends.
// Revision : 1.0  initial release
// ============================================================================
module mem_load_ext
    import mem_lsu_pkg::*;
(
    input  wire logic [31:0] rdata,
    input  wire logic [2:0]  op,
    input  wire logic [1:0]  off,
    output logic      [31:0] result
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (off)
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            2'd3:    w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        w_half = off[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_B:    result = {{24{w_byte[7]}}, w_byte};
            OP_BU:   result = {24'h0, w_byte};
            OP_H:    result = {{16{w_half[15]}}, w_half};
            OP_HU:   result = {16'h0, w_half};
            default: result = rdata;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mem_lsu_queue.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu_queue
// Brief    : In-order MEM-stage load/store queue, up to DEPTH outstanding ops.
//            Optional macro MEM_LSU_BYPASS_EN: same-cycle retire of head data.
// Revision : 1.0  initial release
// ============================================================================
module mem_lsu_queue
    import mem_lsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        in_valid,
    output logic             in_ready,
    input  wire logic        in_is_store,
    input  wire logic [2:0]  in_op,
    input  wire logic [31:0] in_addr,
    input  wire logic [31:0] in_wdata,
    input  wire logic        flush,
    output logic             out_valid,
    input  wire logic        out_ready,
    output logic      [31:0] out_data,
    output logic             out_is_store,
    mem_lsu_queue_if.master  bus,
    output logic             busy
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_head, r_tail, r_resp;
    logic [CNT_W-1:0] r_count, r_pend;
    logic [DEPTH-1:0] r_valid;
    entry_t           r_ent [DEPTH];

    logic        w_full, w_req, w_issue, w_resp, w_head_rdy;
    logic        w_retire, w_cfree, w_bypass, w_dec;
    logic [31:0] w_ext, w_resp_data;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_req   = in_valid & ~w_full & ~flush;
    assign w_issue = w_req & bus.addr_ok;
    // A stray data_ok with nothing outstanding is ignored.
    assign w_resp  = bus.data_ok & (r_pend != '0);

    mem_load_ext u_load_ext (
        .rdata  (bus.rdata),
        .op     (r_ent[r_resp].op),
        .off    (r_ent[r_resp].off),
        .result (w_ext)
    );
    assign w_resp_data = r_ent[r_resp].is_store ? 32'h0 : w_ext;

    assign w_head_rdy = r_valid[r_head] & r_ent[r_head].done & ~r_ent[r_head].cancel;
    assign w_retire   = w_head_rdy & out_ready;
    // Cancelled entries always sit at the head, so freeing one advances head.
    assign w_cfree    = w_resp & r_ent[r_resp].cancel;

`ifdef MEM_LSU_BYPASS_EN
    assign w_bypass = w_resp & ~flush & (r_resp == r_head) & ~r_ent[r_resp].cancel & out_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_dec = w_retire | w_cfree | w_bypass;

    assign bus.req   = w_req;
    assign bus.wr    = in_is_store;
    assign bus.size  = in_op[1:0];
    assign bus.addr  = in_addr;
    assign in_ready  = w_issue;
    assign busy      = |r_valid;

    always_comb begin
        bus.wstrb = 4'b0000;
        bus.wdata = in_wdata;
        if (in_is_store) begin
            case (in_op[1:0])
                SIZE_B:  bus.wstrb = 4'b0001 << in_addr[1:0];
                SIZE_H:  bus.wstrb = 4'b0011 << in_addr[1:0];
                default: bus.wstrb = 4'b1111;
            endcase
        end
        case (in_op[1:0])
            SIZE_B:  bus.wdata = {4{in_wdata[7:0]}};
            SIZE_H:  bus.wdata = {2{in_wdata[15:0]}};
            default: bus.wdata = in_wdata;
        endcase
    end

    always_comb begin
        out_valid    = w_head_rdy | w_bypass;
        out_data     = 32'h0;
        out_is_store = 1'b0;
        if (w_bypass) begin
            out_data     = w_resp_data;
            out_is_store = r_ent[r_resp].is_store;
        end else if (w_head_rdy) begin
            out_data     = r_ent[r_head].data;
            out_is_store = r_ent[r_head].is_store;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_resp  <= '0;
            r_count <= '0;
            r_pend  <= '0;
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else if (flush) begin
            // Done entries vanish now; pending ones linger until their response.
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i]) begin
                    if (r_ent[i].done || (w_resp && (r_resp == PTR_W'(i)))) begin
                        r_valid[i] <= 1'b0;
                    end else begin
                        r_ent[i].cancel <= 1'b1;
                    end
                end
            end
            r_head  <= r_resp + PTR_W'(w_resp);
            r_resp  <= r_resp + PTR_W'(w_resp);
            r_count <= r_pend - CNT_W'(w_resp);
            r_pend  <= r_pend - CNT_W'(w_resp);
        end else begin
            if (w_issue) begin
                r_valid[r_tail] <= 1'b1;
                r_ent[r_tail]   <= '{is_store: in_is_store, op: in_op, off: in_addr[1:0],
                                     done: 1'b0, cancel: 1'b0, data: 32'h0};
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_resp) begin
                if (w_cfree || w_bypass) begin
                    r_valid[r_resp] <= 1'b0;
                end else begin
                    r_ent[r_resp].done <= 1'b1;
                    r_ent[r_resp].data <= w_resp_data;
                end
                r_resp <= r_resp + PTR_W'(1);
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
            end
            r_head  <= r_head + PTR_W'(w_dec);
            r_count <= r_count + CNT_W'(w_issue) - CNT_W'(w_dec);
            r_pend  <= r_pend + CNT_W'(w_issue) - CNT_W'(w_resp);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_lsu_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu_queue
// Brief    : Directed and randomized bench for mem_lsu_queue with a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_lsu_queue;
    import mem_lsu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_is_store, flush, out_ready;
    logic [2:0]  in_op;
    logic [31:0] in_addr, in_wdata;
    logic        in_ready, out_valid, out_is_store, busy;
    logic [31:0] out_data;

    always #5 clk = ~clk;

    mem_lsu_queue_if bus_if ();

    mem_lsu_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_is_store  (in_is_store),
        .in_op        (in_op),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_is_store (out_is_store),
        .bus          (bus_if),
        .busy         (busy)
    );

    typedef struct {
        bit        st;
        bit [2:0]  op;
        bit [1:0]  off;
        bit        done;
        bit        cancel;
        bit [31:0] data;
    } mitem_t;

    mitem_t q[$];
    int     bus_pend = 0;
    int     n_checks = 0;
    int     n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] exp_ext(input bit [2:0] op, input bit [1:0] off, input bit [31:0] rd);
        bit [31:0] b, h;
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * off[1])) & 32'hFFFF;
        case (op)
            3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    function automatic bit [3:0] exp_strb(input bit st, input bit [2:0] op, input bit [1:0] off);
        if (!st) return 4'd0;
        if (op[1:0] == 2'd0) return 4'd1 << off;
        if (op[1:0] == 2'd1) return 4'd3 << off;
        return 4'hF;
    endfunction

    function automatic bit [31:0] exp_wd(input bit [2:0] op, input bit [31:0] wd);
        if (op[1:0] == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (op[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic drive(input bit v, input bit st, input bit [2:0] op, input bit [31:0] a,
                         input bit [31:0] wd, input bit fl, input bit ord, input bit aok,
                         input bit dok, input bit [31:0] rd);
        in_valid = v; in_is_store = st; in_op = op; in_addr = a; in_wdata = wd;
        flush = fl; out_ready = ord;
        bus_if.addr_ok = aok; bus_if.data_ok = dok; bus_if.rdata = rd;
        #1;
    endtask

    task automatic idle(input bit ord);
        drive(0, 0, 3'b010, 32'h0, 32'h0, 0, ord, 0, 0, 32'h0);
    endtask

    // Compare the DUT with the model, clock once, then advance the model.
    task automatic tick();
        bit exp_req, exp_ov;
        int k;
        exp_req = in_valid && (q.size() < DEPTH) && !flush;
        exp_ov  = (q.size() > 0) && q[0].done && !q[0].cancel;
        if (!rst) begin
            chk("req", {31'h0, bus_if.req}, {31'h0, exp_req});
            chk("in_ready", {31'h0, in_ready}, {31'h0, exp_req && bus_if.addr_ok});
            chk("out_valid", {31'h0, out_valid}, {31'h0, exp_ov});
            chk("busy", {31'h0, busy}, {31'h0, q.size() > 0});
            if (exp_ov) begin
                chk("out_data", out_data, q[0].data);
                chk("out_is_store", {31'h0, out_is_store}, {31'h0, q[0].st});
            end
            if (in_valid) begin
                chk("size", {30'h0, bus_if.size}, {30'h0, in_op[1:0]});
                chk("addr", bus_if.addr, in_addr);
                chk("wstrb", {28'h0, bus_if.wstrb}, {28'h0, exp_strb(in_is_store, in_op, in_addr[1:0])});
                chk("wr", {31'h0, bus_if.wr}, {31'h0, in_is_store});
                if (in_is_store) chk("wdata", bus_if.wdata, exp_wd(in_op, in_wdata));
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            bus_pend = 0;
        end else begin
            if (exp_ov && out_ready) void'(q.pop_front());
            if (bus_if.data_ok && bus_pend > 0) begin
                k = 0;
                while (q[k].done) k++;
                if (flush || q[k].cancel) begin
                    q.delete(k);
                end else begin
                    q[k].done = 1;
                    q[k].data = q[k].st ? 32'h0 : exp_ext(q[k].op, q[k].off, bus_if.rdata);
                end
                bus_pend--;
            end
            if (flush) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].done) q.delete(i);
                    else q[i].cancel = 1;
                end
            end
            if (exp_req && bus_if.addr_ok) begin
                q.push_back('{st: in_is_store, op: in_op, off: in_addr[1:0],
                              done: 0, cancel: 0, data: 32'h0});
                bus_pend++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(0); tick(); tick();
        rst = 1'b0;
    endtask

    task automatic issue_load(input bit [31:0] a);
        drive(1, 0, OP_W, a, 32'h0, 0, 0, 1, 0, 32'h0); tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, OP_W, 32'h0, 32'h0, 0, 1, 0, bus_pend > 0, $urandom); tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle(0);
        @(negedge clk);

        // Reset state and sub-word loads.
        do_reset();
        idle(0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_req", {31'h0, bus_if.req}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        tick();
        drive(1, 0, OP_B, 32'h1003, 32'h0, 0, 1, 1, 0, 32'h0); tick();
        drive(0, 0, OP_W, 32'h0, 32'h0, 0, 1, 0, 1, 32'h80FF_FFFF);
        chk("lb_latency", {31'h0, out_valid}, 32'h0);
        tick();
        idle(1);
        chk("lb_valid", {31'h0, out_valid}, 32'h1);
        chk("lb_data", out_data, 32'hFFFF_FF80);
        tick();
        drive(1, 0, OP_BU, 32'h1003, 32'h0, 0, 1, 1, 0, 32'h0); tick();
        drive(0, 0, OP_W, 32'h0, 32'h0, 0, 1, 0, 1, 32'h80FF_FFFF); tick();
        idle(1);
        chk("lbu_data", out_data, 32'h0000_0080);
        tick();

        // Half-word store formatting.
        drive(1, 1, OP_H, 32'h1002, 32'h1234_ABCD, 0, 1, 1, 0, 32'h0);
        chk("sh_wstrb", {28'h0, bus_if.wstrb}, 32'hC);
        chk("sh_wdata", bus_if.wdata, 32'hABCD_ABCD);
        chk("sh_wr", {31'h0, bus_if.wr}, 32'h1);
        tick();
        drive(0, 0, OP_W, 32'h0, 32'h0, 0, 1, 0, 1, 32'h5A5A_5A5A); tick();
        idle(1);
        chk("sh_valid", {31'h0, out_valid}, 32'h1);
        chk("sh_is_store", {31'h0, out_is_store}, 32'h1);
        chk("sh_data", out_data, 32'h0);
        tick();

        // Full queue back-pressure.
        do_reset();
        for (int i = 0; i < DEPTH; i++) issue_load(32'h100 + 4 * i);
        drive(1, 0, OP_W, 32'h200, 32'h0, 0, 0, 1, 0, 32'h0);
        chk("full_req", {31'h0, bus_if.req}, 32'h0);
        tick();
        drive(1, 0, OP_W, 32'h200, 32'h0, 0, 0, 1, 1, 32'h0000_0011); tick();
        drive(1, 0, OP_W, 32'h200, 32'h0, 0, 1, 1, 0, 32'h0);
        chk("full_head_valid", {31'h0, out_valid}, 32'h1);
        chk("full_req_retire", {31'h0, bus_if.req}, 32'h0);
        tick();
        drive(1, 0, OP_W, 32'h200, 32'h0, 0, 1, 1, 0, 32'h0);
        chk("full_req_after", {31'h0, bus_if.req}, 32'h1);
        tick();
        drain(16);

        // Flush with three loads outstanding, then a fresh load.
        do_reset();
        for (int i = 0; i < 3; i++) issue_load(32'h2000 + 4 * i);
        drive(1, 0, OP_W, 32'h2100, 32'h0, 1, 1, 1, 0, 32'h0);
        chk("flush_req", {31'h0, bus_if.req}, 32'h0);
        tick();
        drive(1, 0, OP_W, 32'h3000, 32'h0, 0, 1, 1, 1, 32'h5555_0000); tick();
        for (int i = 1; i < 3; i++) begin
            drive(0, 0, OP_W, 32'h0, 32'h0, 0, 1, 0, 1, 32'h5555_0000 + i);
            chk("flush_discard", {31'h0, out_valid}, 32'h0);
            tick();
        end
        drive(0, 0, OP_W, 32'h0, 32'h0, 0, 1, 0, 1, 32'hDEAD_BEEF);
        chk("flush_discard_last", {31'h0, out_valid}, 32'h0);
        tick();
        idle(1);
        chk("post_flush_valid", {31'h0, out_valid}, 32'h1);
        chk("post_flush_data", out_data, 32'hDEAD_BEEF);
        tick();
        drain(4);

        // Output stall preserves head and order.
        do_reset();
        issue_load(32'h40); issue_load(32'h44);
        drive(0, 0, OP_W, 32'h0, 32'h0, 0, 0, 0, 1, 32'hAAAA_0001); tick();
        drive(0, 0, OP_W, 32'h0, 32'h0, 0, 0, 0, 1, 32'hBBBB_0002); tick();
        for (int i = 0; i < 3; i++) begin
            idle(0);
            chk("stall_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_data", out_data, 32'hAAAA_0001);
            tick();
        end
        idle(1); chk("order_first", out_data, 32'hAAAA_0001); tick();
        idle(1); chk("order_second", out_data, 32'hBBBB_0002); tick();
        idle(1); chk("order_empty", {31'h0, out_valid}, 32'h0); tick();

        // Flush coinciding with the head response.
        do_reset();
        issue_load(32'h80); issue_load(32'h84);
        drive(0, 0, OP_W, 32'h0, 32'h0, 1, 1, 0, 1, 32'h7777_7777); tick();
        idle(1);
        chk("fdok_valid", {31'h0, out_valid}, 32'h0);
        chk("fdok_busy", {31'h0, busy}, 32'h1);
        tick();
        drive(0, 0, OP_W, 32'h0, 32'h0, 0, 1, 0, 1, 32'h8888_8888); tick();
        idle(1);
        chk("fdok_empty", {31'h0, busy}, 32'h0);
        chk("fdok_none", {31'h0, out_valid}, 32'h0);
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit [2:0] ops [5];
            ops[0] = OP_B; ops[1] = OP_H; ops[2] = OP_W; ops[3] = OP_BU; ops[4] = OP_HU;
            drive(($urandom % 4) != 0, $urandom % 2, ops[$urandom_range(0, 4)], $urandom,
                  $urandom, ($urandom % 32) == 0, ($urandom % 4) != 0, $urandom % 2,
                  (bus_pend > 0) && ($urandom % 2 == 1), $urandom);
            tick();
        end
        drain(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_lsu_queue.md
Name: mem_lsu_queue

Overview:
- Parametrised successor to the single-outstanding MEM-stage memory access logic.
- Issues loads and stores on the sram-like bus and tracks up to DEPTH outstanding requests, strictly in order.
- Formats store byte-lanes, sign- or zero-extends load data, and returns results in program order to the writeback side.
- Sits between the EX/MEM pipeline register and the RDW/WB stage. On ex/ertn/tlb flush it cancels in-flight work and silently absorbs late responses.

Parameters:
- DEPTH, 4: maximum outstanding requests (issued, not yet retired); power of 2, range 2..16.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  memory op presented by EX
- in_ready  out  1  op accepted this cycle
- in_is_store  in  1  1 = store, 0 = load
- in_op  in  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
- in_addr  in  32  byte address
- in_wdata  in  32  store source (rkd)
- flush  in  1  ex_flush | ertn_flush | tlb_flush
- out_valid  out  1  head result ready
- out_ready  in  1  downstream accepts result
- out_data  out  32  extended load data; 0 for stores
- out_is_store  out  1  retired op was a store
- req  out  1  bus request
- wr  out  1  write request
- size  out  2  00 byte, 01 half, 10 word
- addr  out  32  bus address
- wstrb  out  4  byte enables
- wdata  out  32  replicated store data
- addr_ok  in  1  request accepted
- data_ok  in  1  response (read data or write ack)
- rdata  in  32  read data
- busy  out  1  any entry allocated, including cancelled ones

Behaviour:
- Reset: out_valid=0, req=0, busy=0, count=0, head=tail=resp ptr=0, all entry valid/done/cancel bits =0, out_data=0.
- Issue:
  - req = in_valid & ~full & ~flush.
  - in_ready = req & addr_ok.
  - On handshake, allocate the entry at tail with {is_store, op, addr[1:0], done=0, cancel=0}; tail advances with wrap mod DEPTH.
- Full: count==DEPTH. req and in_ready are held 0.
- Store formatting:
  - wstrb = byte: 0001<<addr[1:0]; half: 0011<<addr[1:0]; word: 1111.
  - wdata replicated: byte ×4, half ×2.
  - wr = |wstrb for stores; loads drive wstrb=0.
  - Alignment is not checked here; ALE is raised upstream.
- Response: each data_ok completes the oldest not-done entry (resp ptr, in order). The entry captures the extended rdata (store: 0) and sets done. If that entry's cancel=1, it is freed immediately instead of being marked done.
- Load extension: byte/half are selected by addr[1:0]/addr[1]; signed ops sign-extend, unsigned ops zero-extend.
- Output:
  - out_valid registered = head entry valid & done & ~cancel.
  - Retire on out_valid & out_ready; head advances.
  - Latency: data_ok cycle N → out_valid at N+1.
- Count: +1 on issue, -1 on retire or on free of a cancelled entry. Simultaneous +1/-1 leaves count unchanged.
- Flush:
  - Same cycle: req is forced 0.
  - Next cycle: every allocated entry has cancel=1 and out_valid=0.
  - Entries already done are freed immediately.
  - Entries still awaiting data_ok remain allocated until their response, which is then discarded.
  - New issue is allowed the cycle after flush if not full. New entries are uncancelled and their responses follow the cancelled ones in order.
- Flush and data_ok in the same cycle: the response completes the oldest entry, which is then treated as cancelled (discarded).
- Flush and addr_ok in the same cycle: impossible because req=0.
- Reset mid-operation clears all state. Responses arriving after reset are the bus's responsibility (the bus is reset with the core).

Optional Feature:
- MEM_LSU_BYPASS_EN
  - Defined: when the entry completed by data_ok is the head, not cancelled, and out_ready=1, it retires combinationally the same cycle. out_valid/out_data are driven from the extended rdata (0-cycle latency), and no done state is stored.
  - Undefined: registered path only, latency 1.

Decomposition:
- Package mem_lsu_pkg: op encodings (OP_B, OP_H, OP_W, OP_BU, OP_HU), SIZE_* constants, entry struct {is_store, op[2:0], off[1:0], done, cancel, data[31:0]}.
- Sub-module mem_load_ext: combinational rdata + op + offset → 32-bit extended result. Instantiated once on the response path.

Test Plan:
- Load byte at addr 0x1003, rdata 0x80FF_FFFF → out_data 0xFFFF_FF80; byte-unsigned → 0x0000_0080.
- Store half at 0x1002, in_wdata 0x1234_ABCD → wstrb 1100, wdata 0xABCD_ABCD, wr=1, out_is_store=1, out_data=0.
- DEPTH=4: 4 loads issued with addr_ok and no data_ok → 5th has req=0; one data_ok + retire → req=1 the next cycle.
- 3 outstanding loads, flush asserted → out_valid stays 0; the next 3 data_ok are discarded; a new load issued after flush returns its own rdata 0xDEAD_BEEF.
- out_ready held 0 with 2 completed loads → out_valid=1 stable, head data unchanged; releasing out_ready retires them in issue order.
- Flush on the same cycle as data_ok for the head → that result never appears; count decrements by 1.
